cache_repl_policy: RTL and testbench
====================================

# cache_repl_policy

Parametrised per-set replacement-policy unit for the data cache, and the successor of the fixed 4-way LRU tracker. Supports any power-of-two associativity and two policies: exact LRU via rank arrays, or tree pseudo-LRU. Adds invalid-way-first victim selection, an explicit request/valid victim handshake and a post-reset state-initialisation sweep. Sits beside the tag array: the cache controller reports every hit/fill as a touch and queries a victim on a miss.

## Interface
- ASSOC, 4: number of ways; power of two, 2..16.
- CACHE_SIZE, 32768: bytes.
- BLOCK_SIZE, 16: bytes per line.
- ADDR_WIDTH, 32: address width.
- MODE, 0: 0 selects exact LRU; 1 selects tree PLRU.
- Derived values: WAY_W = clog2(ASSOC); OFF_W = clog2(BLOCK_SIZE); SETS = CACHE_SIZE/(BLOCK_SIZE*ASSOC); IDX_W = clog2(SETS). The set index is addr[OFF_W+IDX_W-1:OFF_W].
- clock  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- upd_valid_i  in  1  touch request: mark upd_way_i as most recently used in its set.
- upd_addr_i  in  ADDR_WIDTH  address of the touched line.
- upd_way_i  in  WAY_W  way that was hit or filled.
- vic_req_i  in  1  victim query.
- vic_addr_i  in  ADDR_WIDTH  address whose set is queried.
- way_valid_i  in  ASSOC  valid bits of the queried set, from the tag array, sampled together with vic_req_i.
- vic_valid_o  out  1  one-cycle pulse; vic_way_o is meaningful.
- vic_way_o  out  WAY_W  selected victim way.
- init_busy_o  out  1  high while the state-initialisation sweep runs.

## Operation
- FSM has two states, INIT and RUN.
- Reset enters INIT with the set counter at 0. Reset values: init_busy_o=1, vic_valid_o=0, vic_way_o=0.
- INIT writes the initial state of one set per cycle, sets 0..SETS-1. After writing set SETS-1 the FSM moves to RUN and init_busy_o falls.
- In INIT, upd_valid_i and vic_req_i are ignored. No pulse is produced on vic_valid_o.
- MODE 0 state: per set, an ASSOC-entry rank vector, WAY_W bits per entry. Rank 0 is LRU; rank ASSOC-1 is MRU. Initial state: rank[w]=w.
- MODE 0 touch of way w with current rank r: every way with rank > r decrements by 1, and way w takes rank ASSOC-1. The ranks stay a permutation at all times.
- MODE 1 state: per set, ASSOC-1 tree bits; initial state all 0.
  - A node bit of 0 points toward the lower-numbered half.
  - A touch sets every node on the path to the touched way so it points away from that way.
  - The victim is found by following the node bits from the root.
- Victim selection, in priority order:
  1. If any way_valid_i bit is 0, the victim is the lowest-indexed invalid way.
  2. Otherwise, in MODE 0 the victim is the way with rank 0; in MODE 1 it is the tree-walk result.
- The victim query never modifies policy state. The controller must issue a separate touch after the fill.
- A touch and a query in the same cycle are both accepted, on the same or different sets. The query reads pre-update state (read-before-write).
- rst asserted during RUN aborts any pending result (vic_valid_o=0 next cycle) and restarts INIT.

## Timing
- Touch: state is updated at the clock edge that samples upd_valid_i. A query in the following cycle sees the update.
- Query: vic_req_i sampled at edge N gives vic_valid_o=1 and vic_way_o registered after edge N, in cycle N+1.
- Back-to-back queries are accepted every cycle. There is no backpressure.
- vic_way_o holds its last value while vic_valid_o=0.
- Init duration: exactly SETS cycles after the first edge with rst=0. With the defaults (SETS=512) init_busy_o falls after the 512th such edge.

## Structure
- Shared package cache_pkg holds:
  - the repl_mode_e enum (REPL_LRU=0, REPL_PLRU=1);
  - the derived-width localparam functions (index/offset/way widths);
  - the fsm_e enum (INIT, RUN).
- One sub-module, cache_victim_sel (combinational): given the set's state word, way_valid_i and MODE, it returns the victim way. It is instantiated once, on the query read port.
- State storage is an SETS-deep array. It has one read port per request type, with the write on the update path, so it maps to distributed RAM.

## Test plan
- Reset, then release:
  - init_busy_o stays 1 for 512 cycles, then 0.
  - vic_req_i during INIT produces no vic_valid_o pulse.
- MODE 0, set 5, all valid: touch ways 2, 0, 3 -> query returns 1; then touch 1 -> query returns 2.
- MODE 0, way_valid_i=4'b1011 with any rank state -> vic_way_o=2. With 4'b0000 -> vic_way_o=0.
- After init, touch way 0 and query the same set in the same cycle:
  - that query returns 0;
  - a query in the next cycle returns 1.
- MODE 1, after init: query -> 0; touch 0 -> query 2; touch 2 -> query 1.
- Touch several sets, then assert rst for 1 cycle mid-stream:
  - vic_valid_o=0 and init_busy_o=1;
  - after re-init, set 5 query returns 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and derived-width helpers for the cache replacement-policy block.
package cache_pkg;

  typedef enum logic { REPL_LRU = 1'b0, REPL_PLRU = 1'b1 } repl_mode_e;
  typedef enum logic { INIT = 1'b0, RUN = 1'b1 } fsm_e;

  function automatic int way_w(input int assoc);
    return $clog2(assoc);
  endfunction

  function automatic int off_w(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int idx_w(input int cache_size, input int block_size, input int assoc);
    return $clog2(cache_size / (block_size * assoc));
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Combinational victim picker: lowest invalid way first, else LRU rank-0 way or tree-PLRU walk.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int         ASSOC   = 4,
  parameter repl_mode_e POLICY  = REPL_LRU,
  localparam int        WAY_W   = way_w(ASSOC),
  localparam int        STATE_W = ASSOC * WAY_W
) (
  input  logic [STATE_W-1:0] set_state,
  input  logic [ASSOC-1:0]   way_valid,
  output logic [WAY_W-1:0]   victim
);

  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] plru_way;
  logic             any_inv;
  logic             on_path;
  int               node;
  int               dir;

  always_comb begin
    inv_way  = '0;
    any_inv  = 1'b0;
    lru_way  = '0;
    plru_way = '0;
    on_path  = 1'b0;
    node     = 0;
    dir      = 0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
    for (int w = 0; w < ASSOC; w++) begin
      if (set_state[w*WAY_W +: WAY_W] == '0) lru_way = WAY_W'(w);
    end
    // A way is the PLRU victim when every ancestor's bit steers toward it.
    for (int w = 0; w < ASSOC; w++) begin
      on_path = 1'b1;
      for (int d = 0; d < WAY_W; d++) begin
        node = (ASSOC + w) >> (WAY_W - d);
        dir  = (w >> (WAY_W - 1 - d)) & 1;
        if (int'(set_state[node]) != dir) on_path = 1'b0;
      end
      if (on_path) plru_way = WAY_W'(w);
    end
    if (any_inv)                   victim = inv_way;
    else if (POLICY == REPL_PLRU)  victim = plru_way;
    else                           victim = lru_way;
  end

endmodule

// File: rtl/cache_repl_policy.sv
// Per-set replacement-policy tracker (exact LRU or tree PLRU) with post-reset init sweep.
//   state | meaning
//   INIT  | writing the initial policy word of one set per cycle; requests ignored
//   RUN   | accepting touches and victim queries every cycle
module cache_repl_policy
  import cache_pkg::*;
#(
  parameter int  ASSOC      = 4,
  parameter int  CACHE_SIZE = 32768,
  parameter int  BLOCK_SIZE = 16,
  parameter int  ADDR_WIDTH = 32,
  parameter int  MODE       = 0,
  localparam int WAY_W      = way_w(ASSOC),
  localparam int OFF_W      = off_w(BLOCK_SIZE),
  localparam int IDX_W      = idx_w(CACHE_SIZE, BLOCK_SIZE, ASSOC)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [WAY_W-1:0]      upd_way_i,
  input  logic                  vic_req_i,
  input  logic [ADDR_WIDTH-1:0] vic_addr_i,
  input  logic [ASSOC-1:0]      way_valid_i,
  output logic                  vic_valid_o,
  output logic [WAY_W-1:0]      vic_way_o,
  output logic                  init_busy_o
);

  localparam int         SETS    = CACHE_SIZE / (BLOCK_SIZE * ASSOC);
  // PLRU keeps its tree in bits [ASSOC-1:1] of the same word; bit 0 and the rest stay zero.
  localparam int         STATE_W = ASSOC * WAY_W;
  localparam repl_mode_e POLICY  = (MODE == 1) ? REPL_PLRU : REPL_LRU;

  fsm_e               fsm_cur, fsm_nxt;
  logic               running;
  logic [IDX_W-1:0]   init_cnt;
  logic [STATE_W-1:0] state_mem [SETS];
  logic [IDX_W-1:0]   upd_idx, vic_idx, wr_idx;
  logic [STATE_W-1:0] upd_cur, upd_next, vic_cur, init_word, wr_data;
  logic [WAY_W-1:0]   hit_rank, victim;
  logic               wr_en;
  logic               unused_addr_bits;

  assign upd_idx = upd_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign vic_idx = vic_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign unused_addr_bits = ^{upd_addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], upd_addr_i[OFF_W-1:0],
                              vic_addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], vic_addr_i[OFF_W-1:0]};

  always_ff @(posedge clock) begin
    if (rst) fsm_cur <= INIT;
    else     fsm_cur <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm_cur;
    if (fsm_cur == INIT && init_cnt == IDX_W'(SETS - 1)) fsm_nxt = RUN;
  end

  always_comb begin
    init_busy_o = (fsm_cur == INIT);
    running     = (fsm_cur == RUN);
  end

  always_ff @(posedge clock) begin
    if (rst)              init_cnt <= '0;
    else if (init_busy_o) init_cnt <= init_cnt + 1'b1;
  end

  always_comb begin
    init_word = '0;
    if (POLICY == REPL_LRU) begin
      for (int w = 0; w < ASSOC; w++) init_word[w*WAY_W +: WAY_W] = WAY_W'(w);
    end
  end

  assign upd_cur = state_mem[upd_idx];
  assign vic_cur = state_mem[vic_idx];

  always_comb begin
    upd_next = upd_cur;
    hit_rank = '0;
    if (POLICY == REPL_LRU) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (upd_way_i == WAY_W'(w)) hit_rank = upd_cur[w*WAY_W +: WAY_W];
      end
      for (int w = 0; w < ASSOC; w++) begin
        if (upd_way_i == WAY_W'(w))
          upd_next[w*WAY_W +: WAY_W] = WAY_W'(ASSOC - 1);
        else if (upd_cur[w*WAY_W +: WAY_W] > hit_rank)
          upd_next[w*WAY_W +: WAY_W] = upd_cur[w*WAY_W +: WAY_W] - 1'b1;
      end
    end else begin
      // Node k (heap order) is on the path when it is an ancestor of leaf ASSOC+way.
      for (int k = 1; k < ASSOC; k++) begin
        if (((ASSOC + int'(upd_way_i)) >> (WAY_W - ($clog2(k + 1) - 1))) == k)
          upd_next[k] = ((int'(upd_way_i) >> (WAY_W - $clog2(k + 1))) & 1) == 0;
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = upd_next;
    if (init_busy_o) begin
      wr_en   = 1'b1;
      wr_idx  = init_cnt;
      wr_data = init_word;
    end else if (upd_valid_i) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst && wr_en) state_mem[wr_idx] <= wr_data;
  end

  cache_victim_sel #(
    .ASSOC  (ASSOC),
    .POLICY (POLICY)
  ) u_victim_sel (
    .set_state (vic_cur),
    .way_valid (way_valid_i),
    .victim    (victim)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      vic_valid_o <= 1'b0;
      vic_way_o   <= '0;
    end else begin
      vic_valid_o <= running && vic_req_i;
      if (running && vic_req_i) vic_way_o <= victim;
    end
  end

endmodule

// File: tb/tb_cache_repl_policy.sv
// Bench for cache_repl_policy: one LRU and one PLRU instance share stimulus, checked against list/tree models.
module tb_cache_repl_policy;

  localparam int ASSOC = 4;
  localparam int WAY_W = 2;
  localparam int SETS  = 512;
  localparam int OFF_W = 4;
  localparam int IDX_W = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_addr = '0;
  logic [1:0]  upd_way = '0;
  logic        vic_req = 1'b0;
  logic [31:0] vic_addr = '0;
  logic [3:0]  way_valid = 4'hF;
  logic        vv0, vv1, busy0, busy1;
  logic [1:0]  vw0, vw1;

  int vectors = 0;
  int miscompares = 0;
  int exp0 = 0;
  int exp1 = 0;

  int lru_list [SETS][ASSOC];
  bit pbits    [SETS][WAY_W][ASSOC];

  always #5 clk = ~clk;

  cache_repl_policy #(.MODE(0)) dut_lru (
    .clock(clk), .rst(rst), .upd_valid_i(upd_valid), .upd_addr_i(upd_addr), .upd_way_i(upd_way),
    .vic_req_i(vic_req), .vic_addr_i(vic_addr), .way_valid_i(way_valid),
    .vic_valid_o(vv0), .vic_way_o(vw0), .init_busy_o(busy0));

  cache_repl_policy #(.MODE(1)) dut_plru (
    .clock(clk), .rst(rst), .upd_valid_i(upd_valid), .upd_addr_i(upd_addr), .upd_way_i(upd_way),
    .vic_req_i(vic_req), .vic_addr_i(vic_addr), .way_valid_i(way_valid),
    .vic_valid_o(vv1), .vic_way_o(vw1), .init_busy_o(busy1));

  function automatic logic [31:0] mk_addr(input int s);
    logic [31:0] a;
    a = $urandom;
    a[OFF_W+IDX_W-1:OFF_W] = s[IDX_W-1:0];
    return a;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int i = 0; i < ASSOC; i++) begin
        lru_list[s][i] = i;
        for (int l = 0; l < WAY_W; l++) pbits[s][l][i] = 1'b0;
      end
  endfunction

  // LRU: ordered list, oldest first. PLRU: one direction bit per subtree per level.
  function automatic void model_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < ASSOC; i++) if (lru_list[s][i] == w) p = i;
    for (int i = p; i < ASSOC - 1; i++) lru_list[s][i] = lru_list[s][i+1];
    lru_list[s][ASSOC-1] = w;
    for (int l = 0; l < WAY_W; l++)
      pbits[s][l][w >> (WAY_W - l)] = (((w >> (WAY_W - l - 1)) & 1) == 0);
  endfunction

  function automatic int model_victim(input int mode, input int s, input logic [3:0] v);
    int pos = 0;
    for (int i = 0; i < ASSOC; i++) if (!v[i]) return i;
    if (mode == 0) return lru_list[s][0];
    for (int l = 0; l < WAY_W; l++) pos = pos * 2 + int'(pbits[s][l][pos]);
    return pos;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic uv, input int us, input int uw,
                       input logic rq, input int qs, input logic [3:0] wv);
    upd_valid = uv;
    upd_addr  = mk_addr(us);
    upd_way   = uw[1:0];
    vic_req   = rq;
    vic_addr  = mk_addr(qs);
    way_valid = wv;
    if (rq) begin
      exp0 = model_victim(0, qs, wv);
      exp1 = model_victim(1, qs, wv);
    end
    if (uv) model_touch(us, uw);
    tick();
    upd_valid = 1'b0;
    vic_req   = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    int pulses = 0;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy: got %b/%b expected 1/1", busy0, busy1);
    end
    vectors++;
    if (vv0 !== 1'b0 || vv1 !== 1'b0 || vw0 !== 2'd0 || vw1 !== 2'd0) begin
      miscompares++; $display("FAIL reset_outputs: valid %b/%b way %0d/%0d expected 0", vv0, vv1, vw0, vw1);
    end
    rst = 1'b0;
    while (busy0 === 1'b1 && n < 2000) begin
      vic_req   = 1'b1;
      vic_addr  = mk_addr($urandom_range(0, SETS - 1));
      upd_valid = 1'b1;
      upd_addr  = mk_addr($urandom_range(0, SETS - 1));
      upd_way   = 2'($urandom);
      tick();
      n++;
      if (vv0 !== 1'b0 || vv1 !== 1'b0) pulses++;
    end
    vic_req = 1'b0;
    upd_valid = 1'b0;
    vectors++;
    if (n !== 512) begin
      miscompares++; $display("FAIL init_length: got %0d cycles expected 512", n);
    end
    vectors++;
    if (busy1 !== 1'b0) begin
      miscompares++; $display("FAIL init_plru_done: busy got %b expected 0", busy1);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++; $display("FAIL init_no_pulse: got %0d pulses expected 0", pulses);
    end
    model_reset();
  endtask

  task automatic test_lru_sequence();
    drive(1'b1, 5, 2, 1'b0, 5, 4'hF);
    drive(1'b1, 5, 0, 1'b0, 5, 4'hF);
    drive(1'b1, 5, 3, 1'b0, 5, 4'hF);
    drive(1'b0, 5, 0, 1'b1, 5, 4'hF);
    vectors++;
    if (vv0 !== 1'b1 || vw0 !== 2'd1) begin
      miscompares++; $display("FAIL lru_seq_a: valid %b way %0d expected 1 way 1", vv0, vw0);
    end
    drive(1'b1, 5, 1, 1'b0, 5, 4'hF);
    tick();
    vectors++;
    if (vv0 !== 1'b0 || vw0 !== 2'd1) begin
      miscompares++; $display("FAIL lru_hold: valid %b way %0d expected 0 way 1", vv0, vw0);
    end
    drive(1'b0, 5, 0, 1'b1, 5, 4'hF);
    vectors++;
    if (vv0 !== 1'b1 || vw0 !== 2'd2) begin
      miscompares++; $display("FAIL lru_seq_b: valid %b way %0d expected 1 way 2", vv0, vw0);
    end
  endtask

  task automatic test_invalid_first();
    drive(1'b0, 5, 0, 1'b1, 5, 4'b1011);
    vectors++;
    if (vw0 !== 2'd2 || vw1 !== 2'd2) begin
      miscompares++; $display("FAIL invalid_1011: got %0d/%0d expected 2/2", vw0, vw1);
    end
    drive(1'b0, 5, 0, 1'b1, 5, 4'b0000);
    vectors++;
    if (vw0 !== 2'd0 || vw1 !== 2'd0) begin
      miscompares++; $display("FAIL invalid_0000: got %0d/%0d expected 0/0", vw0, vw1);
    end
  endtask

  task automatic test_plru_sequence();
    drive(1'b0, 9, 0, 1'b1, 9, 4'hF);
    vectors++;
    if (vv1 !== 1'b1 || vw1 !== 2'd0) begin
      miscompares++; $display("FAIL plru_init: valid %b way %0d expected 1 way 0", vv1, vw1);
    end
    drive(1'b1, 9, 0, 1'b0, 9, 4'hF);
    drive(1'b0, 9, 0, 1'b1, 9, 4'hF);
    vectors++;
    if (vw1 !== 2'd2) begin
      miscompares++; $display("FAIL plru_touch0: got %0d expected 2", vw1);
    end
    drive(1'b1, 9, 2, 1'b0, 9, 4'hF);
    drive(1'b0, 9, 0, 1'b1, 9, 4'hF);
    vectors++;
    if (vw1 !== 2'd1) begin
      miscompares++; $display("FAIL plru_touch2: got %0d expected 1", vw1);
    end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 20, 0, 1'b1, 20, 4'hF);
    vectors++;
    if (vv0 !== 1'b1 || vw0 !== 2'd0 || vw1 !== 2'd0) begin
      miscompares++; $display("FAIL same_cycle_rbw: got %0d/%0d expected 0/0", vw0, vw1);
    end
    drive(1'b0, 20, 0, 1'b1, 20, 4'hF);
    vectors++;
    if (vw0 !== 2'd1 || vw1 !== 2'd2) begin
      miscompares++; $display("FAIL same_cycle_next: got %0d/%0d expected 1/2", vw0, vw1);
    end
  endtask

  task automatic test_random();
    logic rq;
    logic [3:0] wv;
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      drive(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), rq, $urandom_range(0, 7), wv);
      vectors++;
      if (vv0 !== rq || vv1 !== rq) begin
        miscompares++; $display("FAIL rand_valid[%0d]: got %b/%b expected %b", i, vv0, vv1, rq);
      end
      vectors++;
      if (vw0 !== 2'(exp0)) begin
        miscompares++; $display("FAIL rand_lru[%0d]: got %0d expected %0d", i, vw0, exp0);
      end
      vectors++;
      if (vw1 !== 2'(exp1)) begin
        miscompares++; $display("FAIL rand_plru[%0d]: got %0d expected %0d", i, vw1, exp1);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    drive(1'b1, 5, 3, 1'b0, 5, 4'hF);
    drive(1'b1, 6, 1, 1'b1, 5, 4'hF);
    upd_valid = 1'b1;
    upd_addr  = mk_addr(7);
    vic_req   = 1'b1;
    vic_addr  = mk_addr(5);
    rst       = 1'b1;
    tick();
    upd_valid = 1'b0;
    vic_req   = 1'b0;
    vectors++;
    if (vv0 !== 1'b0 || vv1 !== 1'b0 || vw0 !== 2'd0 || vw1 !== 2'd0) begin
      miscompares++; $display("FAIL mid_reset_abort: valid %b/%b way %0d/%0d expected 0", vv0, vv1, vw0, vw1);
    end
    vectors++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_busy: got %b/%b expected 1/1", busy0, busy1);
    end
    rst = 1'b0;
    while (busy0 === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 512) begin
      miscompares++; $display("FAIL mid_reset_init: got %0d cycles expected 512", n);
    end
    model_reset();
    drive(1'b0, 5, 0, 1'b1, 5, 4'hF);
    vectors++;
    if (vv0 !== 1'b1 || vw0 !== 2'd0 || vw1 !== 2'd0) begin
      miscompares++; $display("FAIL mid_reset_set5: valid %b way %0d/%0d expected 1 way 0/0", vv0, vw0, vw1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lru_sequence();
    test_invalid_first();
    test_plru_sequence();
    test_same_cycle();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
